// File: rtl/hex_display_scan_if.sv
// Signal bundle between register/counter logic and the 7-segment scan driver.
// The master side supplies the hex value and controls; the slave side drives the pins.
interface hex_display_scan_if #(
  parameter int unsigned DIGITS = 4
);
  logic [4*DIGITS-1:0] i_value;
  logic [DIGITS-1:0]   i_dp_in;
  logic                i_load;
  logic                i_blank_lz;
  logic [6:0]          o_seg;
  logic                o_dp;
  logic [DIGITS-1:0]   o_dig_sel;
  logic                o_frame_tick;

  modport master (
    output i_value,
    output i_dp_in,
    output i_load,
    output i_blank_lz,
    input  o_seg,
    input  o_dp,
    input  o_dig_sel,
    input  o_frame_tick
  );

  modport slave (
    input  i_value,
    input  i_dp_in,
    input  i_load,
    input  i_blank_lz,
    output o_seg,
    output o_dp,
    output o_dig_sel,
    output o_frame_tick
  );
endinterface

// File: rtl/hex_display_scan.sv
// Time-multiplexed DIGITS-wide hex 7-segment driver with frame-synchronous value
// updates, leading-zero blanking and configurable pin polarity.
module hex_display_scan #(
  parameter int unsigned DIGITS      = 4,
  parameter int unsigned REFRESH_DIV = 50000,
  parameter bit          SEG_ACT_LOW = 1'b0,
  parameter bit          DIG_ACT_LOW = 1'b1
) (
  input logic               i_clk,
  input logic               i_rst,
  hex_display_scan_if.slave bus
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
  localparam int unsigned VW = 4 * DIGITS;

  localparam logic [CW-1:0] DIV_LAST = CW'(REFRESH_DIV - 1);
  localparam logic [IW-1:0] IDX_LAST = IW'(DIGITS - 1);

  // Scan position
  logic [CW-1:0] r_div_cnt;
  logic [IW-1:0] r_idx;
  logic [CW-1:0] w_div_cnt_d;
  logic [IW-1:0] w_idx_d;
  logic          w_div_last;
  logic          w_wrap;

  // Displayed and pending value
  logic [VW-1:0]     r_disp;
  logic [DIGITS-1:0] r_disp_dp;
  logic [VW-1:0]     r_pend;
  logic [DIGITS-1:0] r_pend_dp;
  logic              r_pend_valid;
  logic [VW-1:0]     w_disp_d;
  logic [DIGITS-1:0] w_disp_dp_d;
  logic [VW-1:0]     w_pend_d;
  logic [DIGITS-1:0] w_pend_dp_d;
  logic              w_pend_valid_d;

  // Registered pin drivers
  logic              r_wrap;
  logic              r_frame_tick;
  logic [6:0]        r_seg;
  logic              r_dp;
  logic [DIGITS-1:0] r_dig_sel;

  // Current-digit decode
  logic [3:0]        w_nibble;
  logic              w_cur_dp;
  logic              w_cur_blank;
  logic [DIGITS-1:0] w_onehot;
  logic [6:0]        w_glyph;
  logic [6:0]        w_seg_d;

  function automatic logic [6:0] f_decode(input logic [3:0] nib);
    logic [6:0] g;
    g = 7'b0000000;
    unique case (nib)
      4'h0: g = 7'b1111110;
      4'h1: g = 7'b0110000;
      4'h2: g = 7'b1101101;
      4'h3: g = 7'b1111001;
      4'h4: g = 7'b0110011;
      4'h5: g = 7'b1011011;
      4'h6: g = 7'b1011111;
      4'h7: g = 7'b1110000;
      4'h8: g = 7'b1111111;
      4'h9: g = 7'b1111011;
      4'hA: g = 7'b1110111;
      4'hB: g = 7'b0011111;
      4'hC: g = 7'b1001110;
      4'hD: g = 7'b0111101;
      4'hE: g = 7'b1001111;
      4'hF: g = 7'b1000111;
      default: g = 7'b0000000;
    endcase
    return g;
  endfunction

  always_comb begin
    w_div_last  = (r_div_cnt == DIV_LAST);
    w_wrap      = w_div_last && (r_idx == IDX_LAST);
    w_div_cnt_d = w_div_last ? '0 : r_div_cnt + CW'(1);
    w_idx_d     = r_idx;
    if (w_div_last) begin
      w_idx_d = w_wrap ? '0 : r_idx + IW'(1);
    end
  end

  // A load on the wrap cycle bypasses the pending register so it shows this frame.
  always_comb begin
    w_disp_d       = r_disp;
    w_disp_dp_d    = r_disp_dp;
    w_pend_d       = r_pend;
    w_pend_dp_d    = r_pend_dp;
    w_pend_valid_d = r_pend_valid;
    if (w_wrap) begin
      w_pend_valid_d = 1'b0;
      if (bus.i_load) begin
        w_disp_d    = bus.i_value;
        w_disp_dp_d = bus.i_dp_in;
      end else if (r_pend_valid) begin
        w_disp_d    = r_pend;
        w_disp_dp_d = r_pend_dp;
      end
    end else if (bus.i_load) begin
      w_pend_d       = bus.i_value;
      w_pend_dp_d    = bus.i_dp_in;
      w_pend_valid_d = 1'b1;
    end
  end

  // Walk from the most significant digit down, tracking whether everything so far is zero.
  always_comb begin
    logic upper_zero;
    upper_zero  = 1'b1;
    w_nibble    = 4'h0;
    w_cur_dp    = 1'b0;
    w_cur_blank = 1'b0;
    w_onehot    = '0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      upper_zero = upper_zero && (r_disp[4*i +: 4] == 4'h0);
      if (r_idx == IW'(i)) begin
        w_nibble    = r_disp[4*i +: 4];
        w_cur_dp    = r_disp_dp[i];
        w_cur_blank = bus.i_blank_lz && (i != 0) && upper_zero;
        w_onehot[i] = 1'b1;
      end
    end
    w_glyph = f_decode(w_nibble);
    w_seg_d = w_cur_blank ? 7'b0000000 : w_glyph;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_div_cnt <= '0;
      r_idx     <= '0;
    end else begin
      r_div_cnt <= w_div_cnt_d;
      r_idx     <= w_idx_d;
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_disp       <= '0;
      r_disp_dp    <= '0;
      r_pend       <= '0;
      r_pend_dp    <= '0;
      r_pend_valid <= 1'b0;
    end else begin
      r_disp       <= w_disp_d;
      r_disp_dp    <= w_disp_dp_d;
      r_pend       <= w_pend_d;
      r_pend_dp    <= w_pend_dp_d;
      r_pend_valid <= w_pend_valid_d;
    end
  end

  // Wrap is delayed twice so frame_tick lines up with digit 0 appearing on the pins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_wrap       <= 1'b0;
      r_frame_tick <= 1'b0;
      r_seg        <= {7{SEG_ACT_LOW}};
      r_dp         <= SEG_ACT_LOW;
      r_dig_sel    <= {DIGITS{DIG_ACT_LOW}};
    end else begin
      r_wrap       <= w_wrap;
      r_frame_tick <= r_wrap;
      r_seg        <= w_seg_d ^ {7{SEG_ACT_LOW}};
      r_dp         <= w_cur_dp ^ SEG_ACT_LOW;
      r_dig_sel    <= w_onehot ^ {DIGITS{DIG_ACT_LOW}};
    end
  end

  assign bus.o_seg        = r_seg;
  assign bus.o_dp         = r_dp;
  assign bus.o_dig_sel    = r_dig_sel;
  assign bus.o_frame_tick = r_frame_tick;

endmodule

// File: tb/tb_hex_display_scan.sv
// Directed bench for hex_display_scan: a cycle-count based display model is compared
// against the pins every cycle, plus literal expectations at selected scan slots.
module tb_hex_display_scan;

  localparam int D = 4;
  localparam int R = 4;
  localparam int F = D * R;

  localparam logic [6:0] GLYPH [16] = '{
    7'b1111110, 7'b0110000, 7'b1101101, 7'b1111001,
    7'b0110011, 7'b1011011, 7'b1011111, 7'b1110000,
    7'b1111111, 7'b1111011, 7'b1110111, 7'b0011111,
    7'b1001110, 7'b0111101, 7'b1001111, 7'b1000111
  };

  logic clk;
  logic rst;

  hex_display_scan_if #(.DIGITS(D)) bus ();

  hex_display_scan #(
    .DIGITS     (D),
    .REFRESH_DIV(R),
    .SEG_ACT_LOW(1'b0),
    .DIG_ACT_LOW(1'b1)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Model state: n counts edges since the last reset edge.
  int          n = 0;
  bit          model_valid = 1'b0;
  logic [15:0] m_disp, m_pend;
  logic [3:0]  m_dp, m_pend_dp;
  bit          m_pend_v;
  logic [6:0]  e_seg;
  logic        e_dp;
  logic [3:0]  e_dig;
  logic        e_tick;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s n=%0d actual=%0h expected=%0h", name, n, act, exp);
    end
  endtask

  initial begin
    int d;
    logic [15:0] upper;
    forever begin
      @(posedge clk);
      if (rst) begin
        n        = 0;
        m_disp   = '0;
        m_dp     = '0;
        m_pend   = '0;
        m_pend_dp = '0;
        m_pend_v = 1'b0;
        e_seg    = 7'b0000000;
        e_dp     = 1'b0;
        e_dig    = 4'b1111;
        e_tick   = 1'b0;
        model_valid = 1'b1;
      end else begin
        n++;
        d      = ((n - 1) / R) % D;
        upper  = m_disp >> (4 * d);
        e_seg  = (bus.i_blank_lz && d > 0 && upper == 16'h0) ? 7'b0000000
                                                             : GLYPH[int'(upper[3:0])];
        e_dp   = m_dp[d];
        e_dig  = ~(4'b0001 << d);
        e_tick = (n > 1) && ((n - 1) % F == 0);
        if (n % F == 0) begin
          if (bus.i_load) begin
            m_disp = bus.i_value;
            m_dp   = bus.i_dp_in;
          end else if (m_pend_v) begin
            m_disp = m_pend;
            m_dp   = m_pend_dp;
          end
          m_pend_v = 1'b0;
        end else if (bus.i_load) begin
          m_pend    = bus.i_value;
          m_pend_dp = bus.i_dp_in;
          m_pend_v  = 1'b1;
        end
      end
    end
  end

  initial begin
    forever begin
      @(negedge clk);
      if (model_valid) begin
        chk("model_seg", {25'd0, bus.o_seg}, {25'd0, e_seg});
        chk("model_dp", {31'd0, bus.o_dp}, {31'd0, e_dp});
        chk("model_dig_sel", {28'd0, bus.o_dig_sel}, {28'd0, e_dig});
        chk("model_frame_tick", {31'd0, bus.o_frame_tick}, {31'd0, e_tick});
      end
    end
  end

  // Advance to the negedge following edge n with n % F == k.
  task automatic goto_slot(input int k);
    int guard;
    guard = 0;
    do begin
      @(negedge clk);
      guard++;
    end while ((n % F) != k && guard < 64);
    chk("goto_slot", n % F, k);
  endtask

  task automatic load_at_wrap(input logic [15:0] v, input logic [3:0] dpv);
    goto_slot(F - 1);
    bus.i_value = v;
    bus.i_dp_in = dpv;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
  endtask

  task automatic pins(input string name, input logic [6:0] s, input logic p, input logic [3:0] g);
    chk({name, "_seg"}, {25'd0, bus.o_seg}, {25'd0, s});
    chk({name, "_dp"}, {31'd0, bus.o_dp}, {31'd0, p});
    chk({name, "_dig"}, {28'd0, bus.o_dig_sel}, {28'd0, g});
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    int cyc;
    logic [15:0] v;
    rst            = 1'b1;
    bus.i_value    = '0;
    bus.i_dp_in    = '0;
    bus.i_load     = 1'b0;
    bus.i_blank_lz = 1'b0;

    // Reset and first frame
    repeat (3) @(negedge clk);
    pins("reset", 7'b0000000, 1'b0, 4'b1111);
    chk("reset_tick", {31'd0, bus.o_frame_tick}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    pins("release", 7'b1111110, 1'b0, 4'b1110);
    cyc = 1;
    while (bus.o_frame_tick !== 1'b1 && cyc < 40) begin
      @(negedge clk);
      cyc++;
    end
    chk("first_tick_edge", cyc, 17);

    // Mid-frame load holds until the wrap
    goto_slot(6);
    bus.i_value = 16'h1A3F;
    bus.i_dp_in = 4'b0010;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    goto_slot(13);
    pins("no_tear", 7'b1111110, 1'b0, 4'b0111);
    goto_slot(1);
    pins("v1A3F_d0", 7'b1000111, 1'b0, 4'b1110);
    goto_slot(5);
    pins("v1A3F_d1", 7'b1111001, 1'b1, 4'b1101);
    goto_slot(9);
    pins("v1A3F_d2", 7'b1110111, 1'b0, 4'b1011);
    goto_slot(13);
    pins("v1A3F_d3", 7'b0110000, 1'b0, 4'b0111);

    // Every nibble on every digit
    for (int k = 0; k < 16; k++) begin
      for (int i = 0; i < D; i++) v[4*i +: 4] = 4'((k + i) % 16);
      load_at_wrap(v, 4'(k));
    end
    goto_slot(F - 1);

    // Leading-zero blanking
    bus.i_blank_lz = 1'b1;
    load_at_wrap(16'h0040, 4'b0000);
    goto_slot(1);
    pins("lz40_d0", 7'b1111110, 1'b0, 4'b1110);
    goto_slot(5);
    pins("lz40_d1", 7'b0110011, 1'b0, 4'b1101);
    goto_slot(9);
    pins("lz40_d2", 7'b0000000, 1'b0, 4'b1011);
    goto_slot(13);
    pins("lz40_d3", 7'b0000000, 1'b0, 4'b0111);
    load_at_wrap(16'h0000, 4'b1000);
    goto_slot(1);
    pins("lz0_d0", 7'b1111110, 1'b0, 4'b1110);
    goto_slot(5);
    pins("lz0_d1", 7'b0000000, 1'b0, 4'b1101);
    goto_slot(13);
    pins("lz0_d3", 7'b0000000, 1'b1, 4'b0111);
    bus.i_blank_lz = 1'b0;

    // Last load in a frame wins; wrap-cycle load bypasses
    goto_slot(3);
    bus.i_value = 16'h1111;
    bus.i_dp_in = 4'b0000;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_value = 16'h2222;
    @(negedge clk);
    bus.i_load  = 1'b0;
    goto_slot(1);
    pins("last_wins_d0", 7'b1101101, 1'b0, 4'b1110);
    goto_slot(13);
    pins("last_wins_d3", 7'b1101101, 1'b0, 4'b0111);
    load_at_wrap(16'h3333, 4'b0000);
    @(negedge clk);
    pins("bypass_d0", 7'b1111001, 1'b0, 4'b1110);

    // Reset mid-scan discards the pending load
    goto_slot(2);
    bus.i_value = 16'h5555;
    bus.i_load  = 1'b1;
    @(negedge clk);
    bus.i_load  = 1'b0;
    goto_slot(9);
    pins("pre_rst_d2", 7'b1111001, 1'b0, 4'b1011);
    rst = 1'b1;
    @(negedge clk);
    pins("mid_rst", 7'b0000000, 1'b0, 4'b1111);
    chk("mid_rst_tick", {31'd0, bus.o_frame_tick}, 32'd0);
    rst = 1'b0;
    @(negedge clk);
    pins("restart_d0", 7'b1111110, 1'b0, 4'b1110);
    goto_slot(0);
    goto_slot(1);
    pins("pend_dropped_d0", 7'b1111110, 1'b0, 4'b1110);
    chk("restart_tick", {31'd0, bus.o_frame_tick}, 32'd1);
    goto_slot(8);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
